// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath (add, sub, addi,
// lb/lh/lw, sb/sh/sw, auipc, jal). A single memory port is shared by
// instruction fetch and data access, with a variable-latency req/ready
// handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | request instruction at PC; on ready latch IR/OldPC, PC+=4
// DECODE | classify IR fields, register class and funct3
// EXEC   | drive ALU for the class; jal redirects PC here
// MEM    | data access at ALUOut; store retires on ready
// WB     | register file write (ALUOut, MDR or OldPC+4)
// TRAP   | unsupported instruction seen; parked until reset
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             ALUSrc,
  output logic [4:0]       ALUOp,
  output logic [5:0]       EXTOp,
  output logic [2:0]       DMType,
  output logic [1:0]       WDSel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ADD   = 3'd0,
    C_SUB   = 3'd1,
    C_ADDI  = 3'd2,
    C_LOAD  = 3'd3,
    C_STORE = 3'd4,
    C_AUIPC = 3'd5,
    C_JAL   = 3'd6
  } cls_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_SUB   = 5'b00100;

  localparam logic [5:0] EXT_I = 6'b010000;
  localparam logic [5:0] EXT_S = 6'b001000;
  localparam logic [5:0] EXT_U = 6'b000010;
  localparam logic [5:0] EXT_J = 6'b000001;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e     st;
  cls_e       cls;
  logic [2:0] f3;
  logic       illegal_q;
  cls_e       dec_cls;
  logic       dec_ok;
  logic [2:0] dm_f3;
  logic       ls_width_ok;

  // Classify the IR fields; dec_ok low means the encoding is unsupported.
  always_comb begin
    dec_cls     = C_ADD;
    dec_ok      = 1'b0;
    ls_width_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
    case (Op)
      OP_R: begin
        if (Funct3 == 3'b000 && Funct7 == 7'b0000000) begin
          dec_cls = C_ADD;
          dec_ok  = 1'b1;
        end else if (Funct3 == 3'b000 && Funct7 == 7'b0100000) begin
          dec_cls = C_SUB;
          dec_ok  = 1'b1;
        end
      end
      OP_I: begin
        dec_cls = C_ADDI;
        dec_ok  = (Funct3 == 3'b000);
      end
      OP_LOAD: begin
        dec_cls = C_LOAD;
        dec_ok  = ls_width_ok;
      end
      OP_STORE: begin
        dec_cls = C_STORE;
        dec_ok  = ls_width_ok;
      end
      OP_AUIPC: begin
        dec_cls = C_AUIPC;
        dec_ok  = 1'b1;
      end
      OP_JAL: begin
        dec_cls = C_JAL;
        dec_ok  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Sequencer state, latched class/funct3, sticky trap flag and retire count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= S_FETCH;
      cls       <= C_ADD;
      f3        <= 3'b000;
      illegal_q <= 1'b0;
      instr_cnt <= '0;
    end else begin
      case (st)
        S_FETCH: if (mem_ready) st <= S_DECODE;
        S_DECODE: begin
          if (dec_ok) begin
            cls <= dec_cls;
            f3  <= Funct3;
            st  <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            st        <= S_TRAP;
          end
        end
        S_EXEC: st <= (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
        S_MEM: begin
          if (mem_ready) begin
            if (cls == C_STORE) begin
              st        <= S_FETCH;
              instr_cnt <= instr_cnt + CNT_ONE;
            end else begin
              st <= S_WB;
            end
          end
        end
        S_WB: begin
          st        <= S_FETCH;
          instr_cnt <= instr_cnt + CNT_ONE;
        end
        S_TRAP:  st <= S_TRAP;
        default: st <= S_TRAP;
      endcase
    end
  end

  // funct3 -> DMType: lb/sb byte, lh/sh half, lw/sw word.
  always_comb begin
    case (f3)
      3'b000:  dm_f3 = 3'b011;
      3'b001:  dm_f3 = 3'b001;
      default: dm_f3 = 3'b000;
    endcase
  end

  // Moore decode of state/class; everything forced low while rstn is low.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 5'b00000;
    EXTOp    = 6'b000000;
    DMType   = 3'b000;
    WDSel    = 2'b00;
    illegal  = 1'b0;
    state    = 3'b000;
    if (rstn) begin
      state   = st;
      illegal = illegal_q;
      case (st)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_EXEC: begin
          case (cls)
            C_ADD: ALUOp = ALU_ADD;
            C_SUB: ALUOp = ALU_SUB;
            C_ADDI, C_LOAD: begin
              ALUSrc = 1'b1;
              EXTOp  = EXT_I;
              ALUOp  = ALU_ADD;
            end
            C_STORE: begin
              ALUSrc = 1'b1;
              EXTOp  = EXT_S;
              ALUOp  = ALU_ADD;
            end
            C_AUIPC: begin
              ALUSrcA = 1'b1;
              ALUSrc  = 1'b1;
              EXTOp   = EXT_U;
              ALUOp   = ALU_AUIPC;
            end
            C_JAL: begin
              ALUSrcA = 1'b1;
              ALUSrc  = 1'b1;
              EXTOp   = EXT_J;
              ALUOp   = ALU_ADD;
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            default: ALUOp = 5'b00000;
          endcase
        end
        S_MEM: begin
          // Extension select held from EXEC so the address path stays quiet.
          mem_req = 1'b1;
          IorD    = 1'b1;
          mem_we  = (cls == C_STORE);
          DMType  = dm_f3;
          EXTOp   = (cls == C_STORE) ? EXT_S : EXT_I;
        end
        S_WB: begin
          RegWrite = 1'b1;
          if (cls == C_LOAD) begin
            DMType = dm_f3;
            WDSel  = 2'b01;
          end else if (cls == C_JAL) begin
            WDSel = 2'b10;
          end
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: each instruction is expanded into the
// expected cycle-by-cycle output trace from the sequencing rules and compared
// against the DUT on the falling clock edge.
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [6:0]       Op;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic             mem_ready;
  logic             mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWrite;
  logic             ALUSrcA, ALUSrc;
  logic [4:0]       ALUOp;
  logic [5:0]       EXTOp;
  logic [2:0]       DMType;
  logic [1:0]       WDSel;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp),
    .DMType(DMType), .WDSel(WDSel), .illegal(illegal), .state(state),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, regwrite;
    logic       alusrca, alusrc;
    logic [4:0] aluop;
    logic [5:0] extop;
    logic [2:0] dmtype;
    logic [1:0] wdsel;
    logic       illegal;
  } exp_t;

  exp_t dut_vec;
  assign dut_vec = {state, mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc,
                    RegWrite, ALUSrcA, ALUSrc, ALUOp, EXTOp, DMType, WDSel, illegal};

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LOAD = 3, K_STORE = 4,
                 K_AUIPC = 5, K_JAL = 6, K_BAD = 7;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t blank(input logic [2:0] s);
    exp_t e;
    e = '0;
    e.state = s;
    return e;
  endfunction

  task automatic step(input logic rdy, input exp_t e, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check(tag, 32'(dut_vec), 32'(e));
    check({tag, "_cnt"}, 32'(instr_cnt), 32'(model_cnt % (1 << CNT_W)));
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    mem_ready = 1'b1;
    #1;
    model_cnt = 0;
    check({tag, "_outs"}, 32'(dut_vec), 32'd0);
    check({tag, "_cnt"}, 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mem_ready = 1'b0;
  endtask

  // Executes one instruction: kind, access width (0 byte,1 half,2 word),
  // fetch/memory wait cycles; abort pulls reset in the first MEM cycle.
  task automatic run_instr(input int kind, input int width, input int fw,
                           input int mw, input bit abort);
    exp_t e;
    logic [2:0] dm;
    logic [5:0] ls_ext;
    int bad;
    dm = (width == 0) ? 3'b011 : (width == 1) ? 3'b001 : 3'b000;
    Funct7 = 7'($urandom_range(0, 127));
    Funct3 = 3'(width);
    case (kind)
      K_ADD:   begin Op = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'b0000000; end
      K_SUB:   begin Op = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'b0100000; end
      K_ADDI:  begin Op = 7'b0010011; Funct3 = 3'b000; end
      K_LOAD:  Op = 7'b0000011;
      K_STORE: Op = 7'b0100011;
      K_AUIPC: Op = 7'b0010111;
      K_JAL:   Op = 7'b1101111;
      default: begin
        bad = $urandom_range(0, 5);
        case (bad)
          0: Op = 7'h7F;
          1: begin Op = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'b0000001; end
          2: begin Op = 7'b0110011; Funct3 = 3'b001; Funct7 = 7'b0000000; end
          3: begin Op = 7'b0000011; Funct3 = 3'b100; end
          4: begin Op = 7'b0100011; Funct3 = 3'b011; end
          default: begin Op = 7'b0010011; Funct3 = 3'b001; end
        endcase
      end
    endcase

    for (int i = 0; i < fw; i++) begin
      e = blank(3'd0); e.mem_req = 1'b1;
      step(1'b0, e, "fetch_wait");
    end
    e = blank(3'd0); e.mem_req = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    step(1'b1, e, "fetch_done");

    step(1'($urandom_range(0, 1)), blank(3'd1), "decode");

    if (kind == K_BAD) begin
      for (int i = 0; i < 20; i++) begin
        e = blank(3'd5); e.illegal = 1'b1;
        step(1'($urandom_range(0, 1)), e, "trap");
      end
      reset_pulse("trap_reset");
      return;
    end

    e = blank(3'd2);
    case (kind)
      K_ADD: e.aluop = 5'b00011;
      K_SUB: e.aluop = 5'b00100;
      K_ADDI, K_LOAD: begin e.alusrc = 1; e.extop = 6'b010000; e.aluop = 5'b00011; end
      K_STORE: begin e.alusrc = 1; e.extop = 6'b001000; e.aluop = 5'b00011; end
      K_AUIPC: begin e.alusrca = 1; e.alusrc = 1; e.extop = 6'b000010; e.aluop = 5'b00010; end
      default: begin
        e.alusrca = 1; e.alusrc = 1; e.extop = 6'b000001; e.aluop = 5'b00011;
        e.pcwrite = 1; e.pcsrc = 1;
      end
    endcase
    step(1'($urandom_range(0, 1)), e, "exec");

    if (kind == K_LOAD || kind == K_STORE) begin
      ls_extop_sel: ls_ext = (kind == K_STORE) ? 6'b001000 : 6'b010000;
      for (int i = 0; i <= mw; i++) begin
        e = blank(3'd3); e.mem_req = 1; e.iord = 1; e.mem_we = (kind == K_STORE);
        e.dmtype = dm; e.extop = ls_ext;
        step((i == mw) ? 1'b1 : 1'b0, e, "mem");
        if (abort) begin
          #1 rstn = 1'b0;
          #1;
          model_cnt = 0;
          check("abort_mem_req", 32'(mem_req), 32'd0);
          check("abort_outs", 32'(dut_vec), 32'd0);
          @(negedge clk);
          rstn = 1'b1;
          mem_ready = 1'b0;
          e = blank(3'd0); e.mem_req = 1'b1;
          step(1'b0, e, "post_abort_fetch");
          return;
        end
      end
      if (kind == K_STORE) begin
        model_cnt++;
        return;
      end
    end

    e = blank(3'd4); e.regwrite = 1;
    if (kind == K_LOAD) begin e.dmtype = dm; e.wdsel = 2'b01; end
    if (kind == K_JAL) e.wdsel = 2'b10;
    step(1'($urandom_range(0, 1)), e, "wb");
    model_cnt++;
  endtask

  initial begin
    int k;
    rstn = 1'b0;
    mem_ready = 1'b1;
    Op = '0; Funct3 = '0; Funct7 = '0;
    #2;
    check("reset_outs", 32'(dut_vec), 32'd0);
    check("reset_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mem_ready = 1'b0;

    run_instr(K_ADD, 0, 0, 0, 1'b0);
    run_instr(K_LOAD, 2, 0, 2, 1'b0);
    run_instr(K_STORE, 0, 0, 0, 1'b0);
    run_instr(K_JAL, 0, 1, 0, 1'b0);
    run_instr(K_SUB, 0, 0, 0, 1'b0);
    run_instr(K_AUIPC, 0, 0, 0, 1'b0);
    run_instr(K_ADDI, 0, 2, 0, 1'b0);
    run_instr(K_LOAD, 1, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      k = (($urandom_range(0, 9)) == 0) ? K_BAD : $urandom_range(0, 6);
      run_instr(k, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    for (int n = 0; n < 20; n++)
      run_instr(K_ADD, 0, 0, 0, 1'b0);

    run_instr(K_BAD, 0, 0, 0, 1'b0);
    run_instr(K_ADD, 0, 0, 0, 1'b0);
    run_instr(K_LOAD, 2, 0, 1, 1'b1);
    run_instr(K_STORE, 1, 1, 1, 1'b1);
    run_instr(K_ADDI, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32 datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Fetch and data accesses share one memory port, with a variable-latency req/ready handshake.
- It drives the same control encodings (ALUOp, EXTOp, WDSel, DMType) as the single-cycle decoder, plus the multi-cycle strobes PCWrite, IRWrite and IorD.
- Supported set: add, sub, addi, lb, lh, lw, sb, sh, sw, auipc, jal.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
Op  in  7  opcode from IR (valid from DECODE onward)
Funct3  in  3  funct3 from IR
Funct7  in  7  funct7 from IR
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write enable (qualifies mem_req)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
IRWrite  out  1  latch instruction into IR and the current PC into OldPC
PCWrite  out  1  update PC
PCSrc  out  1  next-PC select: 0=PC+4, 1=ALU result (jump target)
RegWrite  out  1  register file write strobe
ALUSrcA  out  1  ALU A select: 0=rs1, 1=OldPC
ALUSrc  out  1  ALU B select: 0=rs2, 1=immediate
ALUOp  out  5  add=5'b00011, auipc=5'b00010, sub=5'b00100, nop=0
EXTOp  out  6  I=6'b010000, S=6'b001000, U=6'b000010, J=6'b000001
DMType  out  3  word=000, half=001, byte=011
WDSel  out  2  00=ALUOut, 01=MDR, 10=OldPC+4
illegal  out  1  sticky unsupported-instruction flag
state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset and output timing
  - Reset is asynchronous on rstn falling. state=FETCH, cls=0, f3=0, instr_cnt=0, illegal=0.
  - While rstn=0, every output is 0; combinational outputs are gated with rstn.
  - Outputs are a Moore decode of state and registered cls/f3. The only exception is that IRWrite and PCWrite are also qualified by mem_ready in FETCH.
- FETCH
  - mem_req=1, IorD=0, mem_we=0.
  - Holds while mem_ready=0.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 with PCSrc=0 in the same cycle, then go to DECODE.
- DECODE (1 cycle)
  - Classifies Op/Funct3/Funct7 into one of: R-add, R-sub, addi, load, store, auipc, jal.
  - Registers the class in cls and Funct3 in f3.
  - Unsupported encodings (other opcodes, R with other funct, load/store funct3 outside 000/001/010, addi funct3≠000) go to TRAP. Everything else goes to EXEC.
- EXEC (1 cycle)
  - R: ALUSrc=0, ALUOp add or sub. Next WB.
  - addi: ALUSrc=1, EXTOp=I, ALUOp=add. Next WB.
  - auipc: ALUSrcA=1, ALUSrc=1, EXTOp=U, ALUOp=auipc. Next WB.
  - load/store: ALUSrc=1, EXTOp=I (load) or S (store), ALUOp=add; the datapath latches ALUOut. Next MEM.
  - jal: ALUSrcA=1, ALUSrc=1, EXTOp=J, ALUOp=add, PCWrite=1, PCSrc=1. Next WB.
- MEM
  - mem_req=1, IorD=1, mem_we=(store), DMType from f3.
  - Holds while mem_ready=0.
  - On ready: a store retires and goes to FETCH; a load goes to WB (the datapath latches MDR).
- WB (1 cycle)
  - RegWrite=1, DMType held for loads.
  - WDSel: 01 for load, 10 for jal, 00 otherwise.
  - Next FETCH.
- TRAP
  - illegal=1, all strobes 0, mem_req=0. Stays in TRAP until rstn.
- instr_cnt
  - Increments by 1 on each retiring transition: WB→FETCH, or MEM→FETCH for a store.
  - Wraps modulo 2^CNT_W. Does not count in TRAP.
- Handshake rule
  - mem_req stays high until the cycle mem_ready=1 is sampled.
  - mem_ready outside FETCH/MEM is ignored.
  - Address, we and DMType are stable while mem_req is held.
- Latency with zero-wait memory
  - R/addi/auipc/jal/load: 4/4/4/4/5 cycles.
  - store: 4 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset then add (Op=0110011, F7=0, F3=0), mem_ready=1 → states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=00011 in EXEC; instr_cnt=1 after 4 cycles.
- lw (Op=0000011, F3=010), mem_ready low 2 cycles in MEM → MEM lasts 3 cycles with mem_req=1, IorD=1, mem_we=0, DMType=000; WB has WDSel=01; total 7 cycles.
- sb (Op=0100011, F3=000) → MEM has mem_we=1, DMType=011, EXTOp=001000; RegWrite never asserted; returns to FETCH after MEM; instr_cnt increments.
- jal (Op=1101111) → EXEC has PCWrite=1, PCSrc=1, EXTOp=000001; WB has RegWrite=1, WDSel=10.
- Op=7'h7F → TRAP after DECODE; illegal=1, mem_req=0 held for 20 cycles; rstn pulse → FETCH, illegal=0, instr_cnt=0.
- rstn asserted mid-MEM with mem_req=1 → mem_req drops to 0 immediately (asynchronous); after release, FETCH with mem_req=1, no spurious RegWrite or PCWrite.
